irq_ctrl: RTL and testbench

Machine-mode interrupt and trap controller for the multicycle RV32 core. It sits directly upstream of the CSR unit. It synchronises and registers the interrupt sources into `mip`, and arbitrates between synchronous exceptions and enabled interrupts. It then issues the single-cycle `trap_pending` strobe and `trap_cause` that the CSR unit uses to capture `mepc`, `mcause`, `mtval` and `mstatus`. A two-state tracker blocks interrupt re-entry until `trap_finish` (MRET) retires the handler.

---
 rtl/irq_ctrl_pkg.sv | 25 ++
 rtl/sync_ff.sv | 20 ++
 rtl/irq_ctrl.sv | 84 ++++++++
 tb/tb_irq_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared interrupt/trap constants for irq_ctrl and the CSR unit.
package irq_ctrl_pkg;

  localparam int MEIP_BIT = 11;
  localparam int MTIP_BIT = 7;
  localparam int MSIP_BIT = 3;

  localparam logic [4:0] MEI_CODE = 5'd11;
  localparam logic [4:0] MSI_CODE = 5'd3;
  localparam logic [4:0] MTI_CODE = 5'd7;

  localparam logic [4:0] INST_ADDR_MISALIGN  = 5'd0;
  localparam logic [4:0] ILLEGAL_INST        = 5'd2;
  localparam logic [4:0] ENV_BREAK           = 5'd3;
  localparam logic [4:0] LOAD_ADDR_MISALIGN  = 5'd4;
  localparam logic [4:0] STORE_ADDR_MISALIGN = 5'd6;
  localparam logic [4:0] ENV_CALL_M          = 5'd11;

  typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} irq_state_t;

  function automatic logic [31:0] irq_cause(input logic [4:0] code);
    return {1'b1, 26'b0, code};
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-flop synchroniser for a single asynchronous level, cleared to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt/trap arbiter: registers sources into mip, picks
// exception over interrupt, and blocks interrupt re-entry until MRET.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ext_irq,
  input  logic        sw_irq,
  input  logic        timer_irq,
  input  logic [31:0] mie,
  input  logic        irq_en,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic        int_window,
  input  logic        trap_finish,
  output logic [31:0] mip,
  output logic [31:0] trap_cause,
  output logic        trap_pending
);

  logic       ext_sync, sw_q, timer_q;
  logic       irq_any;
  irq_state_t state;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ext_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ext_irq),
    .q     (ext_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q    <= 1'b0;
      timer_q <= 1'b0;
    end else begin
      sw_q    <= sw_irq;
      timer_q <= timer_irq;
    end
  end

  always_comb begin
    mip           = '0;
    mip[MEIP_BIT] = ext_sync;
    mip[MTIP_BIT] = timer_q;
    mip[MSIP_BIT] = sw_q;
  end

  assign irq_any = |(mip & mie);

  // Outputs are forced low while reset is held so the CSR unit never
  // captures a trap during reset, even with exc_valid floating high.
  always_comb begin
    trap_pending = 1'b0;
    trap_cause   = '0;
    if (rst_n) begin
      if (exc_valid) begin
        trap_pending = 1'b1;
        trap_cause   = {27'b0, exc_cause};
      end else if (state == RUN && int_window && irq_en && irq_any) begin
        trap_pending = 1'b1;
        if (mip[MEIP_BIT] && mie[MEIP_BIT])      trap_cause = irq_cause(MEI_CODE);
        else if (mip[MSIP_BIT] && mie[MSIP_BIT]) trap_cause = irq_cause(MSI_CODE);
        else                                     trap_cause = irq_cause(MTI_CODE);
      end
    end
  end

  // A nested exception keeps us in HANDLER even if MRET retires alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else begin
      case (state)
        RUN:     if (trap_pending) state <= HANDLER;
        HANDLER: if (trap_finish && !exc_valid) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model of mip, arbitration and handler tracking.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int SYNC = 2;

  logic        clk = 0, rst_n = 0;
  logic        ext_irq = 0, sw_irq = 0, timer_irq = 0;
  logic [31:0] mie = 0;
  logic        irq_en = 0, exc_valid = 0, int_window = 0, trap_finish = 0;
  logic [4:0]  exc_cause = 0;
  logic [31:0] mip, trap_cause;
  logic        trap_pending;

  int checks = 0, passes = 0;

  // model state
  bit [3:1] m_ext_hist;
  bit       m_sw, m_tm, m_handler;

  irq_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ext_irq(ext_irq), .sw_irq(sw_irq),
    .timer_irq(timer_irq), .mie(mie), .irq_en(irq_en), .exc_valid(exc_valid),
    .exc_cause(exc_cause), .int_window(int_window), .trap_finish(trap_finish),
    .mip(mip), .trap_cause(trap_cause), .trap_pending(trap_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_mip();
    logic [31:0] m = 0;
    if (m_ext_hist[SYNC]) m = m + 32'h800;
    if (m_tm)             m = m + 32'h80;
    if (m_sw)             m = m + 32'h8;
    return m;
  endfunction

  function automatic void model_out(output bit p, output logic [31:0] c);
    logic [31:0] act = model_mip() & mie;
    p = 0; c = 0;
    if (exc_valid) begin
      p = 1; c = 32'(exc_cause);
    end else if (!m_handler && int_window && irq_en && act != 0) begin
      p = 1;
      if (act[11])     c = 32'h8000_000B;
      else if (act[3]) c = 32'h8000_0003;
      else             c = 32'h8000_0007;
    end
  endfunction

  function automatic void model_reset();
    m_ext_hist = 0; m_sw = 0; m_tm = 0; m_handler = 0;
  endfunction

  task automatic check_model(input string name);
    bit p; logic [31:0] c;
    #2;
    model_out(p, c);
    checks++; if (mip !== model_mip()) $display("FAIL %s mip: got %h want %h", name, mip, model_mip()); else passes++;
    checks++; if (trap_pending !== p) $display("FAIL %s trap_pending: got %b want %b", name, trap_pending, p); else passes++;
    checks++; if (trap_cause !== c) $display("FAIL %s trap_cause: got %h want %h", name, trap_cause, c); else passes++;
  endtask

  task automatic step();
    bit p; logic [31:0] c;
    @(posedge clk);
    model_out(p, c);
    if (p) m_handler = 1;
    else if (trap_finish) m_handler = 0;
    m_ext_hist = {m_ext_hist[2:1], ext_irq};
    m_sw = sw_irq; m_tm = timer_irq;
    #1;
  endtask

  task automatic leave_handler(input string name);
    int_window = 0; trap_finish = 1;
    check_model(name);
    step();
    trap_finish = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (mip !== 0) $display("FAIL reset mip: got %h want 0", mip); else passes++;
    checks++; if (trap_pending !== 0) $display("FAIL reset trap_pending: got %b want 0", trap_pending); else passes++;
    @(posedge clk); #1;
    rst_n = 1; model_reset();
    check_model("post_reset");
    step();
  endtask

  task automatic test_sync_latency();
    ext_irq = 1; mie = 32'h800; irq_en = 1; int_window = 1;
    check_model("sync_e0"); step();
    check_model("sync_e1");
    checks++; if (mip !== 0) $display("FAIL sync_e1 mip: got %h want 0", mip); else passes++;
    step();
    check_model("sync_e2");
    checks++; if (mip !== 32'h800) $display("FAIL sync_e2 mip: got %h want 800", mip); else passes++;
    checks++; if (trap_cause !== 32'h8000_000B || trap_pending !== 1)
      $display("FAIL sync_trap: got %b/%h want 1/8000000b", trap_pending, trap_cause); else passes++;
    step();
    check_model("sync_once");
    checks++; if (trap_pending !== 0) $display("FAIL sync_once pending: got %b want 0", trap_pending); else passes++;
    leave_handler("sync_leave");
  endtask

  task automatic test_priority();
    logic [31:0] want [3] = '{32'h8000_000B, 32'h8000_0003, 32'h8000_0007};
    ext_irq = 1; sw_irq = 1; timer_irq = 1; mie = 32'h888; irq_en = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) ext_irq = 0;
      if (k == 2) sw_irq = 0;
      int_window = 0;
      for (int i = 0; i < 3; i++) begin check_model("prio_settle"); step(); end
      int_window = 1;
      check_model("prio");
      checks++; if (trap_cause !== want[k]) $display("FAIL prio%0d cause: got %h want %h", k, trap_cause, want[k]); else passes++;
      step();
      leave_handler("prio_leave");
    end
  endtask

  task automatic test_exc_over_irq();
    int pulses = 0;
    int_window = 1; exc_valid = 1; exc_cause = ILLEGAL_INST;
    check_model("exc");
    checks++; if (trap_cause !== 32'h2) $display("FAIL exc cause: got %h want 00000002", trap_cause); else passes++;
    if (trap_pending) pulses++;
    step();
    exc_valid = 0;
    check_model("exc_after");
    if (trap_pending) pulses++;
    checks++; if (pulses !== 1) $display("FAIL exc pulses: got %0d want 1", pulses); else passes++;
  endtask

  task automatic test_reentry_block();
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      check_model("reentry_hold");
      if (trap_pending) pulses++;
      step();
    end
    checks++; if (pulses !== 0) $display("FAIL reentry pulses: got %0d want 0", pulses); else passes++;
    trap_finish = 1;
    check_model("reentry_mret"); step();
    trap_finish = 0;
    check_model("reentry_next");
    checks++; if (trap_pending !== 1 || trap_cause !== 32'h8000_0007)
      $display("FAIL reentry trap: got %b/%h want 1/80000007", trap_pending, trap_cause); else passes++;
    step();
  endtask

  task automatic test_simultaneous();
    trap_finish = 1; exc_valid = 1; exc_cause = ENV_BREAK;
    check_model("simul");
    checks++; if (trap_pending !== 1 || trap_cause !== 32'h3)
      $display("FAIL simul trap: got %b/%h want 1/00000003", trap_pending, trap_cause); else passes++;
    step();
    exc_valid = 0; trap_finish = 0;
    checks++; if (dut.state !== HANDLER) $display("FAIL simul state: got %0d want HANDLER", dut.state); else passes++;
    leave_handler("simul_leave");
  endtask

  task automatic test_reset_mid_handler();
    ext_irq = 1; sw_irq = 1; timer_irq = 1; mie = 32'h888; irq_en = 1; int_window = 1;
    for (int i = 0; i < 4; i++) begin check_model("rst_enter"); step(); end
    checks++; if (dut.state !== HANDLER) $display("FAIL rst_pre state: got %0d want HANDLER", dut.state); else passes++;
    #2 rst_n = 0; #1;
    checks++; if (mip !== 0) $display("FAIL rst_mid mip: got %h want 0", mip); else passes++;
    checks++; if (trap_pending !== 0) $display("FAIL rst_mid pending: got %b want 0", trap_pending); else passes++;
    checks++; if (dut.state !== RUN) $display("FAIL rst_mid state: got %0d want RUN", dut.state); else passes++;
    @(posedge clk); #1;
    rst_n = 1; model_reset();
    ext_irq = 0; sw_irq = 0; timer_irq = 0; int_window = 0;
    check_model("rst_release"); step();
  endtask

  task automatic test_random();
    logic [4:0] codes [6] = '{INST_ADDR_MISALIGN, ILLEGAL_INST, ENV_BREAK,
                              LOAD_ADDR_MISALIGN, STORE_ADDR_MISALIGN, ENV_CALL_M};
    logic [31:0] mies [5] = '{32'h0, 32'h8, 32'h80, 32'h800, 32'h888};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
      if ($urandom_range(0, 7) == 0) sw_irq = ~sw_irq;
      if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
      if ($urandom_range(0, 15) == 0) mie = ($urandom_range(0, 1) == 1) ? $urandom() : mies[$urandom_range(0, 4)];
      irq_en      = ($urandom_range(0, 3) != 0);
      int_window  = ($urandom_range(0, 1) == 1);
      exc_valid   = ($urandom_range(0, 9) == 0);
      exc_cause   = codes[$urandom_range(0, 5)];
      trap_finish = ($urandom_range(0, 3) == 0);
      check_model("random");
      step();
    end
    exc_valid = 0; trap_finish = 0;
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_priority();
    test_exc_over_irq();
    test_reentry_block();
    test_simultaneous();
    test_reset_mid_handler();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
